// File: rtl/logip_pkg.sv
// Shared definitions for the logic-analyser trigger path: SUMP opcodes,
// divider type, flag field layout and the group-disable lane helper.
package logip_pkg;

    localparam int SUMP_DIVW = 24;

    localparam logic [7:0] CMD_SET_DIV   = 8'h80;
    localparam logic [7:0] CMD_SET_FLAGS = 8'h82;

    localparam int FLG_GDIS_LO = 2;
    localparam int FLG_GDIS_HI = 5;
    localparam int NUM_GDIS    = FLG_GDIS_HI - FLG_GDIS_LO + 1;

    typedef logic [SUMP_DIVW-1:0] div_t;
    typedef logic [NUM_GDIS-1:0]  gdis_t;

    // Groups beyond the flag field have no disable bit and always pass through.
    function automatic logic lane_masked(input int g, input gdis_t gdis);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < NUM_GDIS; i++) begin
            if (i == g && gdis[i]) hit = 1'b1;
        end
        return hit;
    endfunction

endpackage

// File: rtl/sync_ff.sv
// Multi-flop synchroniser for asynchronous inputs; latency STAGES cycles,
// no backpressure. Chain resets to zero.
module sync_ff #(
    parameter int WIDTH  = 1,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] chain [STAGES];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < STAGES; s++) chain[s] <= '0;
        end else begin
            chain[0] <= d;
            for (int s = 1; s < STAGES; s++) chain[s] <= chain[s-1];
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/sampler.sv
// Probe front end: synchronise, divide to sample rate, apply group disables.
// Latency SYNC_STAGES+1 from input to smpls_o; no backpressure, stb_o is a pure strobe.
module sampler
    import logip_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int DIVW        = 24,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk_i,
    input  logic             rst_in,
    input  logic [31:0]      cmd_i,
    input  logic             set_div_i,
    input  logic             set_flags_i,
    input  logic             en_i,
    input  logic [WIDTH-1:0] input_i,
    output logic [WIDTH-1:0] smpls_o,
    output logic             stb_o
);

    localparam int GROUPS = WIDTH / 8;
    localparam logic [DIVW-1:0] CNT_ONE = {{(DIVW-1){1'b0}}, 1'b1};

    logic [DIVW-1:0]  div;
    logic [DIVW-1:0]  cnt;
    gdis_t            gdis;
    logic [WIDTH-1:0] sync_word;
    logic [WIDTH-1:0] masked;

    sync_ff #(
        .WIDTH  (WIDTH),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk   (clk_i),
        .rst_n (rst_in),
        .d     (input_i),
        .q     (sync_word)
    );

    always_comb begin
        masked = sync_word;
        for (int g = 0; g < GROUPS; g++) begin
            if (lane_masked(g, gdis)) masked[8*g +: 8] = 8'h00;
        end
    end

    // A divider write restarts the period, so it wins over strobe generation.
    always_ff @(posedge clk_i or negedge rst_in) begin
        if (!rst_in) begin
            div     <= '0;
            cnt     <= '0;
            gdis    <= '0;
            smpls_o <= '0;
            stb_o   <= 1'b0;
        end else begin
            if (set_flags_i) gdis <= cmd_i[FLG_GDIS_HI:FLG_GDIS_LO];

            if (set_div_i) begin
                div   <= cmd_i[DIVW-1:0];
                cnt   <= '0;
                stb_o <= 1'b0;
            end else if (!en_i) begin
                cnt   <= '0;
                stb_o <= 1'b0;
            end else if (cnt == div) begin
                cnt     <= '0;
                stb_o   <= 1'b1;
                smpls_o <= masked;
            end else begin
                cnt   <= cnt + CNT_ONE;
                stb_o <= 1'b0;
            end
        end
    end

    generate
        if (DIVW < 32) begin : g_cmd_hi
            logic unused_cmd_hi;
            assign unused_cmd_hi = ^cmd_i[31:DIVW];
        end
    endgenerate

endmodule

// File: tb/tb_sampler.sv
// Self-checking bench for sampler: directed vector table, hand sequences for
// multi-cycle corners, then randomized stimulus against a reference model.
module tb_sampler;

    localparam int W    = 32;
    localparam int SYNC = 2;

    logic          clk;
    logic          rst_n;
    logic [31:0]   cmd;
    logic          set_div;
    logic          set_flags;
    logic          en;
    logic [W-1:0]  din;
    logic [W-1:0]  smpls;
    logic          stb;

    int total;
    int passed;

    sampler #(.WIDTH(W), .DIVW(24), .SYNC_STAGES(SYNC)) dut (
        .clk_i       (clk),
        .rst_in      (rst_n),
        .cmd_i       (cmd),
        .set_div_i   (set_div),
        .set_flags_i (set_flags),
        .en_i        (en),
        .input_i     (din),
        .smpls_o     (smpls),
        .stb_o       (stb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: sample period expressed as enabled cycles since the last restart.
    longint       m_div;
    longint       m_run;
    logic [3:0]   m_gdis;
    logic [W-1:0] m_hist[$];
    logic [W-1:0] m_smpls;
    logic         m_stb;

    function automatic logic [W-1:0] apply_mask(input logic [W-1:0] w, input logic [3:0] gd);
        logic [W-1:0] r;
        r = w;
        for (int g = 0; g < 4; g++) if (gd[g]) r[8*g +: 8] = 8'h00;
        return r;
    endfunction

    task automatic model_reset();
        m_div = 0;
        m_run = 0;
        m_gdis = 4'h0;
        m_smpls = '0;
        m_stb = 1'b0;
        m_hist.delete();
        for (int i = 0; i < SYNC; i++) m_hist.push_back('0);
    endtask

    task automatic model_edge();
        logic [W-1:0] oldest;
        longint       pdiv;
        logic [3:0]   pgd;
        oldest = m_hist[$];
        pdiv = m_div;
        pgd  = m_gdis;
        if (set_div) begin
            m_div = longint'(cmd[23:0]);
            m_run = 0;
            m_stb = 1'b0;
        end else if (!en) begin
            m_run = 0;
            m_stb = 1'b0;
        end else begin
            m_stb = ((m_run % (pdiv + 1)) == pdiv);
            if (m_stb) m_smpls = apply_mask(oldest, pgd);
            m_run = m_run + 1;
        end
        if (set_flags) m_gdis = cmd[5:2];
        m_hist.push_front(din);
        void'(m_hist.pop_back());
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    task automatic step(input logic sd, input logic sf, input logic e,
                        input logic [31:0] c, input logic [W-1:0] d);
        set_div = sd;
        set_flags = sf;
        en = e;
        cmd = c;
        din = d;
        @(posedge clk);
        model_edge();
        #1;
    endtask

    typedef struct {
        logic         sd;
        logic         sf;
        logic         e;
        logic [31:0]  c;
        logic [W-1:0] d;
        logic         exp_stb;
        logic [W-1:0] exp_smpls;
    } vec_t;

    vec_t vecs[9];

    initial begin
        total = 0;
        passed = 0;
        rst_n = 1'b0;
        set_div = 1'b0;
        set_flags = 1'b0;
        en = 1'b0;
        cmd = '0;
        din = '0;
        model_reset();

        vecs[0] = '{1'b1, 1'b0, 1'b1, 32'h0,  32'hA5A5_5A5A, 1'b0, 32'h0000_0000};
        vecs[1] = '{1'b0, 1'b0, 1'b1, 32'h0,  32'hA5A5_5A5A, 1'b1, 32'h0000_0000};
        vecs[2] = '{1'b0, 1'b0, 1'b1, 32'h0,  32'hA5A5_5A5A, 1'b1, 32'hA5A5_5A5A};
        vecs[3] = '{1'b0, 1'b0, 1'b1, 32'h0,  32'hA5A5_5A5A, 1'b1, 32'hA5A5_5A5A};
        vecs[4] = '{1'b0, 1'b1, 1'b1, 32'h14, 32'hFFFF_FFFF, 1'b1, 32'hA5A5_5A5A};
        vecs[5] = '{1'b0, 1'b0, 1'b1, 32'h0,  32'hFFFF_FFFF, 1'b1, 32'hA500_5A00};
        vecs[6] = '{1'b0, 1'b0, 1'b1, 32'h0,  32'hFFFF_FFFF, 1'b1, 32'hFF00_FF00};
        vecs[7] = '{1'b0, 1'b0, 1'b0, 32'h0,  32'hFFFF_FFFF, 1'b0, 32'hFF00_FF00};
        vecs[8] = '{1'b1, 1'b0, 1'b0, 32'h3,  32'hFFFF_FFFF, 1'b0, 32'hFF00_FF00};

        #12;
        check("reset_stb", {31'b0, stb}, 32'h0);
        check("reset_smpls", smpls, 32'h0);
        rst_n = 1'b1;
        #4;

        for (int i = 0; i < 9; i++) begin
            step(vecs[i].sd, vecs[i].sf, vecs[i].e, vecs[i].c, vecs[i].d);
            check($sformatf("vec%0d_stb", i), {31'b0, stb}, {31'b0, vecs[i].exp_stb});
            check($sformatf("vec%0d_smpls", i), smpls, vecs[i].exp_smpls);
        end

        // div=3: strobe on every 4th enabled edge
        for (int i = 0; i < 12; i++) begin
            step(1'b0, 1'b0, 1'b1, 32'h0, 32'hFFFF_FFFF);
            check($sformatf("div3_stb%0d", i), {31'b0, stb}, {31'b0, (i % 4) == 3});
            if ((i % 4) == 3) check("div3_smpls", smpls, 32'hFF00_FF00);
        end

        // div=9 with enable dropped at cnt=5
        step(1'b0, 1'b0, 1'b0, 32'h0, 32'hFFFF_FFFF);
        step(1'b1, 1'b0, 1'b0, 32'h9, 32'hFFFF_FFFF);
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b0, 1'b1, 32'h0, 32'hFFFF_FFFF);
            check("div9_pre_stb", {31'b0, stb}, 32'h0);
        end
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 1'b0, 32'h0, 32'hFFFF_FFFF);
            check("en_low_stb", {31'b0, stb}, 32'h0);
        end
        for (int i = 0; i < 12; i++) begin
            step(1'b0, 1'b0, 1'b1, 32'h0, 32'hFFFF_FFFF);
            check($sformatf("reen_stb%0d", i), {31'b0, stb}, {31'b0, i == 9});
        end

        // mid-count divider write at cnt=7
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b1, 32'h0, 32'hFFFF_FFFF);
        step(1'b1, 1'b0, 1'b1, 32'h1, 32'hFFFF_FFFF);
        check("setdiv_mid_stb", {31'b0, stb}, 32'h0);
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b0, 1'b1, 32'h0, 32'hFFFF_FFFF);
            check($sformatf("div1_stb%0d", i), {31'b0, stb}, {31'b0, (i % 2) == 1});
        end

        // asynchronous reset mid-period with div=5, all groups disabled
        step(1'b1, 1'b0, 1'b1, 32'h5, 32'hFFFF_FFFF);
        step(1'b0, 1'b1, 1'b1, 32'h3C, 32'hFFFF_FFFF);
        step(1'b0, 1'b0, 1'b1, 32'h0, 32'hFFFF_FFFF);
        step(1'b0, 1'b0, 1'b1, 32'h0, 32'hFFFF_FFFF);
        check("prerst_smpls", smpls, 32'hFF00_FF00);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check("async_rst_stb", {31'b0, stb}, 32'h0);
        check("async_rst_smpls", smpls, 32'h0);
        #2;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 1'b1, 32'h0, 32'hFFFF_FFFF);
            check($sformatf("postrst_stb%0d", i), {31'b0, stb}, 32'h1);
            check($sformatf("postrst_smpls%0d", i), smpls, (i == 2) ? 32'hFFFF_FFFF : 32'h0);
        end

        // randomized traffic against the reference model
        for (int i = 0; i < 3000; i++) begin
            logic        sd, sf, e;
            logic [31:0] c;
            sd = ($urandom_range(0, 29) == 0);
            sf = ($urandom_range(0, 14) == 0);
            e  = ($urandom_range(0, 9) != 0);
            if (sd) c = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 6));
            else    c = $urandom;
            step(sd, sf, e, c, $urandom);
            check("rnd_stb", {31'b0, stb}, {31'b0, m_stb});
            check("rnd_smpls", smpls, m_smpls);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
